gpr_file: RTL and testbench
===========================

# gpr_file

Parametrised general-purpose register file for the single-cycle/multi-cycle CPU datapath: two combinational read ports, one write port, hardwired-zero register 0, and write-through bypass. Adds a sequenced bulk-clear engine (one entry per cycle, with busy flag) and a display scan port that walks the register contents for the board's LED/seven-segment output. This replaces fixed per-register display taps with a single indexed port.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; DEPTH = 2**ADDR_W entries
- DISP_W, 2, low-order bits of each register presented on the scan port (1..DATA_W)

- clock_in  in  1  system clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- reg_write  in  1  write enable
- write_reg  in  ADDR_W  write address
- write_data  in  DATA_W  write data
- read_reg1  in  ADDR_W  read port 1 address
- read_reg2  in  ADDR_W  read port 2 address
- read_data1  out  DATA_W  read port 1 data, combinational
- read_data2  out  DATA_W  read port 2 data, combinational
- clear_req  in  1  request a sequenced clear of all registers
- busy  out  1  high while a clear is in progress
- scan_tick  in  1  single-cycle pulse advancing the display scan
- scan_idx  out  ADDR_W  register index currently displayed
- scan_data  out  DISP_W  low DISP_W bits of register scan_idx, registered

## Operation
- Storage: DEPTH x DATA_W flops; entry 0 is never written and always reads 0.
- Write: on rising edge when reg_write=1, busy=0, write_reg!=0 -> entry[write_reg] <= write_data. Writes to 0 are dropped silently.
- Read: read_dataN = 0 if read_regN==0; else write_data if reg_write=1, busy=0 and write_reg==read_regN (bypass); else entry[read_regN].
- Clear FSM, states IDLE, CLEAR:
  - IDLE: busy=0. clear_req=1 sampled -> CLEAR, clr_ptr <= 1. A write in that same cycle is still performed and is cleared later by the sweep.
  - CLEAR: busy=1. Each cycle entry[clr_ptr] <= 0, clr_ptr++. When clr_ptr==DEPTH-1 is cleared -> IDLE. All reg_write requests ignored; bypass disabled; clear_req ignored.
  - Reads during CLEAR return current contents (partially cleared state visible).
  - DEPTH==2: a single CLEAR cycle.
- Scan: on scan_tick=1, scan_idx <= scan_idx+1, wrapping DEPTH-1 -> 0. Every cycle scan_data <= entry[scan_idx][DISP_W-1:0], sampled from stored contents (no bypass). Scan continues unaffected by busy.

## Timing
- Reset (reset_n=0, asynchronous): all entries 0, state IDLE, clr_ptr=1, busy=0, scan_idx=0, scan_data=0. read_data1/2 read 0 while reset is held. Reset asserted mid-clear aborts the sweep; IDLE on release.
- Write latency: stored value visible on read port from the cycle after the write edge; same-cycle visibility via bypass.
- busy rises the cycle after clear_req is sampled and stays high exactly DEPTH-1 cycles.
- scan_data lags stored contents by one cycle: a write at edge k shows on scan_data after edge k+1 if scan_idx matches. After a scan_tick at edge k, scan_idx updates at k; scan_data reflects the new index after k+1.
- reset_n deassertion is synchronised externally; no internal synchroniser.

## Structure
- Shared package gpr_pkg: clear-FSM state enum (GPR_IDLE, GPR_CLEAR), and DATA_W/ADDR_W defaults used by the datapath and control unit.
- Sub-module gpr_scan_ctr: wrap-around index counter with tick enable, parametrised by ADDR_W; the storage array, bypass and clear FSM stay in gpr_file.

## Test plan
- Reset then write 0xDEADBEEF to r5, read r5 on both ports next cycle -> 0xDEADBEEF; write 0x1234 to r0 -> r0 reads 0.
- Bypass: reg_write=1, write_reg=7, write_data=0xA5, read_reg1=7 same cycle -> read_data1=0xA5 before the edge.
- Fill r1..r31 with index value, pulse clear_req -> busy high 31 cycles; write to r3 at cycle 10 of clear ignored; r3 reads 0 after busy falls.
- clear_req and write r4=0x55 in same IDLE cycle -> r4 reads 0x55 during the first CLEAR cycle, then 0 after the sweep reaches it.
- Assert reset_n=0 at cycle 5 of a clear with r20=0x77 still uncleared -> busy=0, r20=0, scan_idx=0 immediately.
- Load rN=N, issue 33 scan_ticks -> scan_idx wraps to 1; scan_data = idx[1:0] one cycle after each tick (DISP_W=2).

Source files
------------

// File: rtl/gpr_pkg.sv
// Shared types and default widths for the general-purpose register file.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gpr_pkg;

    localparam int GPR_DATA_W = 32;
    localparam int GPR_ADDR_W = 5;

    // Bulk-clear sequencer states
    typedef enum logic {
        GPR_IDLE  = 1'b0,
        GPR_CLEAR = 1'b1
    } gpr_state_e;

endpackage

// File: rtl/gpr_scan_ctr.sv
// Wrap-around display scan index, advanced by a single-cycle tick.
// Latency: index updates on the edge that samples tick.
// Backpressure: none; every tick is taken.
module gpr_scan_ctr #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    output logic [ADDR_W-1:0] idx
);

    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] idx_d;

    // Next index: power-of-two depth, so natural overflow gives the wrap to 0
    always_comb begin
        idx_d = idx_q;
        if (tick) begin
            idx_d = idx_q + ADDR_W'(1);
        end
    end

    // Index register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx = idx_q;

endmodule

// File: rtl/gpr_file.sv
// Register file: 2 combinational reads, 1 write with bypass, r0 hardwired 0, sequenced clear, display scan.
// Latency: reads combinational; write visible next cycle (same cycle via bypass); scan_data lags one cycle.
// Backpressure: writes and clear requests are dropped while busy; no stalls are generated.
module gpr_file
    import gpr_pkg::*;
#(
    parameter int DATA_W = GPR_DATA_W,
    parameter int ADDR_W = GPR_ADDR_W,
    parameter int DISP_W = 2
) (
    input  logic              clock_in,
    input  logic              reset_n,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    input  logic              clear_req,
    output logic              busy,
    input  logic              scan_tick,
    output logic [ADDR_W-1:0] scan_idx,
    output logic [DISP_W-1:0] scan_data
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] FIRST_PTR = ADDR_W'(1);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];

    gpr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic              busy_q, busy_d;
    logic [DISP_W-1:0] scan_data_q, scan_data_d;
    logic              wr_en;

    // A write only lands when idle and not aimed at r0; it also gates the bypass
    assign wr_en = reg_write && (state_q == GPR_IDLE) && (write_reg != '0);

    // Read ports: r0 and held reset read zero, otherwise bypass beats storage
    always_comb begin
        read_data1 = regs_q[read_reg1];
        read_data2 = regs_q[read_reg2];
        if (wr_en && (write_reg == read_reg1)) read_data1 = write_data;
        if (wr_en && (write_reg == read_reg2)) read_data2 = write_data;
        if (!reset_n || (read_reg1 == '0)) read_data1 = '0;
        if (!reset_n || (read_reg2 == '0)) read_data2 = '0;
    end

    // Storage next state: a normal write or one step of the clear sweep (mutually exclusive)
    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[write_reg] = write_data;
        end
        if (state_q == GPR_CLEAR) begin
            regs_d[clr_ptr_q] = '0;
        end
    end

    // Clear sequencer next state; the sweep starts at r1 since r0 is never written
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        busy_d    = busy_q;
        case (state_q)
            GPR_IDLE: begin
                if (clear_req) begin
                    state_d   = GPR_CLEAR;
                    clr_ptr_d = FIRST_PTR;
                    busy_d    = 1'b1;
                end
            end
            GPR_CLEAR: begin
                if (clr_ptr_q == LAST_PTR) begin
                    state_d   = GPR_IDLE;
                    clr_ptr_d = FIRST_PTR;
                    busy_d    = 1'b0;
                end else begin
                    clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d   = GPR_IDLE;
                clr_ptr_d = FIRST_PTR;
                busy_d    = 1'b0;
            end
        endcase
    end

    // Display sample comes from stored contents only, never the bypass path
    always_comb begin
        scan_data_d = regs_q[scan_idx][DISP_W-1:0];
    end

    // Storage array
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Clear sequencer with registered busy output; reset aborts any sweep in progress
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= GPR_IDLE;
            clr_ptr_q <= FIRST_PTR;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            busy_q    <= busy_d;
        end
    end

    // Registered display data
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            scan_data_q <= '0;
        end else begin
            scan_data_q <= scan_data_d;
        end
    end

    gpr_scan_ctr #(
        .ADDR_W(ADDR_W)
    ) u_scan_ctr (
        .clk  (clock_in),
        .rst_n(reset_n),
        .tick (scan_tick),
        .idx  (scan_idx)
    );

    assign busy      = busy_q;
    assign scan_data = scan_data_q;

endmodule

// File: tb/tb_gpr_file.sv
// Directed bench for gpr_file: reset, write/read, r0, bypass, bulk clear, reset abort, scan.
// Inputs change 1 time unit after the rising edge; outputs are checked before the next edge.
// Every check is an immediate assertion feeding the total/bad counters.
module tb_gpr_file;

    logic        clock_in;
    logic        reset_n;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic        clear_req;
    logic        busy;
    logic        scan_tick;
    logic [4:0]  scan_idx;
    logic [1:0]  scan_data;

    int total = 0;
    int bad   = 0;
    int cnt;

    gpr_file dut (
        .clock_in  (clock_in),
        .reset_n   (reset_n),
        .reg_write (reg_write),
        .write_reg (write_reg),
        .write_data(write_data),
        .read_reg1 (read_reg1),
        .read_reg2 (read_reg2),
        .read_data1(read_data1),
        .read_data2(read_data2),
        .clear_req (clear_req),
        .busy      (busy),
        .scan_tick (scan_tick),
        .scan_idx  (scan_idx),
        .scan_data (scan_data)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock_in);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        reg_write  = 1'b1;
        write_reg  = a;
        write_data = d;
        step();
        reg_write  = 1'b0;
    endtask

    initial begin
        // Reset held with a live write request: reads must still show 0
        reset_n    = 1'b0;
        reg_write  = 1'b1;
        write_reg  = 5'd5;
        write_data = 32'hCAFE_F00D;
        read_reg1  = 5'd5;
        read_reg2  = 5'd0;
        clear_req  = 1'b0;
        scan_tick  = 1'b0;
        #2;
        chk("reset_rd1", read_data1, 32'h0);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_scan_idx", {27'b0, scan_idx}, 32'h0);
        chk("reset_scan_data", {30'b0, scan_data}, 32'h0);
        reg_write = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();

        // Basic write then read on both ports
        wr(5'd5, 32'hDEAD_BEEF);
        read_reg1 = 5'd5;
        read_reg2 = 5'd5;
        #1;
        chk("r5_port1", read_data1, 32'hDEAD_BEEF);
        chk("r5_port2", read_data2, 32'hDEAD_BEEF);

        // Writes to r0 are dropped and the bypass never exposes them
        reg_write  = 1'b1;
        write_reg  = 5'd0;
        write_data = 32'h1234;
        read_reg1  = 5'd0;
        #1;
        chk("r0_no_bypass", read_data1, 32'h0);
        step();
        reg_write = 1'b0;
        #1;
        chk("r0_after_write", read_data1, 32'h0);

        // Same-cycle bypass, and storage on the other port still old
        reg_write  = 1'b1;
        write_reg  = 5'd7;
        write_data = 32'hA5;
        read_reg1  = 5'd7;
        read_reg2  = 5'd5;
        #1;
        chk("bypass_r7", read_data1, 32'hA5);
        chk("no_bypass_r5", read_data2, 32'hDEAD_BEEF);
        step();
        reg_write = 1'b0;

        // Fill r1..r31 with their index
        for (int i = 1; i < 32; i++) wr(5'(i), 32'(i));
        read_reg1 = 5'd31;
        #1;
        chk("fill_r31", read_data1, 32'd31);

        // Clear request together with a write to r4 in the same idle cycle
        clear_req  = 1'b1;
        reg_write  = 1'b1;
        write_reg  = 5'd4;
        write_data = 32'h55;
        step();
        clear_req = 1'b0;
        reg_write = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            if (cnt == 1) begin
                read_reg1 = 5'd4;
                #1;
                chk("r4_first_clear_cycle", read_data1, 32'h55);
            end
            if (cnt == 10) begin
                reg_write  = 1'b1;
                write_reg  = 5'd3;
                write_data = 32'h99;
                read_reg1  = 5'd3;
                read_reg2  = 5'd30;
                #1;
                chk("clear_bypass_off", read_data1, 32'h0);
                chk("clear_partial_r30", read_data2, 32'd30);
            end
            step();
            reg_write = 1'b0;
        end
        chk("busy_cycles", cnt, 32'd31);
        read_reg1 = 5'd3;
        read_reg2 = 5'd4;
        #1;
        chk("r3_after_clear", read_data1, 32'h0);
        chk("r4_after_clear", read_data2, 32'h0);
        read_reg1 = 5'd31;
        read_reg2 = 5'd5;
        #1;
        chk("r31_after_clear", read_data1, 32'h0);
        chk("r5_after_clear", read_data2, 32'h0);

        // Reset in the middle of a clear sweep
        wr(5'd20, 32'h77);
        clear_req = 1'b1;
        scan_tick = 1'b1;
        step();
        clear_req = 1'b0;
        for (int i = 0; i < 4; i++) step();
        scan_tick = 1'b0;
        read_reg1 = 5'd20;
        #1;
        chk("r20_before_abort", read_data1, 32'h77);
        chk("busy_before_abort", {31'b0, busy}, 32'h1);
        chk("scan_idx_before_abort", {27'b0, scan_idx}, 32'd5);
        reset_n = 1'b0;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_r20", read_data1, 32'h0);
        chk("abort_scan_idx", {27'b0, scan_idx}, 32'h0);
        #2;
        reset_n = 1'b1;
        step();
        chk("after_abort_busy", {31'b0, busy}, 32'h0);
        read_reg1 = 5'd20;
        #1;
        chk("after_abort_r20", read_data1, 32'h0);

        // Scan walk: rN = N, 33 ticks, data one cycle after each tick
        for (int i = 1; i < 32; i++) wr(5'(i), 32'(i));
        chk("scan_idx_start", {27'b0, scan_idx}, 32'h0);
        for (int k = 1; k <= 33; k++) begin
            scan_tick = 1'b1;
            step();
            scan_tick = 1'b0;
            chk("scan_idx", {27'b0, scan_idx}, 32'(k % 32));
            step();
            chk("scan_data", {30'b0, scan_data}, 32'((k % 32) & 3));
        end

        // scan_data lag on a write to the displayed register (idx = 1)
        wr(5'd1, 32'h2);
        chk("scan_lag_old", {30'b0, scan_data}, 32'h1);
        step();
        chk("scan_lag_new", {30'b0, scan_data}, 32'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
